// File: rtl/seg_pkg.sv
// Shared definitions for the message sequencer and the 7-segment letter decoder:
// index width, default message length, FSM/direction encodings and the index stepping rule.
package seg_pkg;

    // Width of the message index consumed by the letter decoder.
    localparam int IDX_W       = 4;
    // Default number of letters in the message (index 0..MSG_LEN_DEF-1).
    localparam int MSG_LEN_DEF = 16;
    // Prescaler and debounce counter widths.
    localparam int PRESC_W     = 24;
    localparam int DEB_W       = 16;

    // Sequencer states, kept as plain constants so older blocks can share them.
    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_PAUSE = 1'b1;

    // Direction encodings.
    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_REV = 1'b1;

    typedef logic [IDX_W-1:0] idx_t;

    // Result of one index step: the new position and whether it wrapped.
    typedef struct packed {
        idx_t idx;
        logic wrap;
    } step_t;

    // Registered press pulses, one per front-panel button.
    typedef struct packed {
        logic run;
        logic step;
        logic dir;
    } btn_t;

    // Move one position in the given direction, wrapping at both ends with explicit
    // compares so that message lengths shorter than 2**IDX_W wrap correctly.
    function automatic step_t next_index(input idx_t cur, input logic dir, input idx_t last);
        step_t r;
        r.idx  = cur;
        r.wrap = 1'b0;
        if (dir == DIR_FWD) begin
            if (cur == last) begin
                r.idx  = '0;
                r.wrap = 1'b1;
            end else begin
                r.idx = cur + idx_t'(1);
            end
        end else begin
            if (cur == '0) begin
                r.idx  = last;
                r.wrap = 1'b1;
            end else begin
                r.idx = cur - idx_t'(1);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/msg_stepper_if.sv
// Control/status bundle between the front panel (buttons, switches, debug pins)
// and the message sequencer. The panel side is the master.
interface msg_stepper_if;
    import seg_pkg::*;

    // Panel controls
    logic       ena;
    logic       btn_run;
    logic       btn_step;
    logic       btn_dir;
    logic [1:0] speed;

    // Sequencer status
    idx_t       index;
    logic       tick;
    logic       wrap;
    logic       running;
    logic       dir;

    modport master (
        output ena, btn_run, btn_step, btn_dir, speed,
        input  index, tick, wrap, running, dir
    );

    modport slave (
        input  ena, btn_run, btn_step, btn_dir, speed,
        output index, tick, wrap, running, dir
    );

endinterface

// File: rtl/btn_debounce.sv
// Raw mechanical button -> synchronised, debounced level plus a one-cycle press pulse.
// A level change is accepted only after DEB_CYCLES consecutive cycles of the new value;
// only rising edges of the accepted level produce a press.
module btn_debounce
    import seg_pkg::*;
#(
    parameter logic [DEB_W-1:0] DEB_CYCLES = 16'd50_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic press
);

    logic             sync_meta;
    logic             sync_q;
    logic [DEB_W-1:0] cnt_q;
    logic             level_d;

    // Two-flop synchroniser for the asynchronous button input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= 1'b0;
            sync_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking so both flops sample pre-edge values and form a true two-stage chain.
            sync_meta <= raw;
            sync_q    <= sync_meta;
        end
    end

    // Count consecutive cycles the synced value disagrees with the accepted level; accept when long enough.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            level <= 1'b0;
        end else if (sync_q == level) begin
            cnt_q <= '0;
        end else if (cnt_q == DEB_CYCLES - DEB_W'(1)) begin
            cnt_q <= '0;
            level <= sync_q;
        end else begin
            cnt_q <= cnt_q + DEB_W'(1);
        end
    end

    // Delayed copy of the accepted level for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_d <= 1'b0;
        end else begin
            level_d <= level;
        end
    end

    // Press on the rising edge of the accepted level only; releases are silent.
    assign press = level & ~level_d;

endmodule

// File: rtl/msg_stepper.sv
// Message index sequencer feeding the 7-segment letter decoder.
// RUN: a prescaler advances the index every (MAX_COUNT >> speed)+1 cycles.
// PAUSE: the prescaler is parked at zero and the step button advances one position.
// Run toggles RUN/PAUSE, dir toggles direction; all button presses are debounced.
module msg_stepper
    import seg_pkg::*;
#(
    parameter logic [PRESC_W-1:0] MAX_COUNT  = 24'd10_000_000,
    parameter logic [DEB_W-1:0]   DEB_CYCLES = 16'd50_000,
    parameter int                 MSG_LEN    = MSG_LEN_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    msg_stepper_if.slave bus
);

    localparam idx_t LAST_IDX = idx_t'(MSG_LEN - 1);

    // Button path outputs. The accepted levels are not needed here; presses carry everything.
    logic [2:0]         btn_level_unused;
    logic               press_run;
    logic               press_step;
    logic               press_dir;

    // Sequencer state
    logic [PRESC_W-1:0] presc_q;
    logic [0:0]         state_q;
    idx_t               index_q;
    logic               tick_q;
    logic               wrap_q;
    logic               dir_q;

    // Next-state helpers
    btn_t               press_en;
    logic [PRESC_W-1:0] term;
    logic               presc_hit;
    logic               step_ok;
    logic               do_adv;
    step_t              nxt;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_run (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (bus.btn_run),
        .level (btn_level_unused[0]),
        .press (press_run)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_step (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (bus.btn_step),
        .level (btn_level_unused[1]),
        .press (press_step)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_dir (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (bus.btn_dir),
        .level (btn_level_unused[2]),
        .press (press_dir)
    );

    // Decide this cycle's presses, prescaler terminal and whether the index advances.
    always_comb begin
        // NOTE: every signal driven here is assigned on every path, so no latch can be inferred.
        press_en.run  = press_run  & bus.ena;
        press_en.step = press_step & bus.ena;
        press_en.dir  = press_dir  & bus.ena;
        term          = MAX_COUNT >> bus.speed;
        // >= rather than == so a mid-count speed increase fires next cycle instead of overflowing.
        presc_hit     = (state_q == ST_RUN) && (presc_q >= term);
        // A run press in PAUSE takes priority and drops a coincident step.
        step_ok       = (state_q == ST_PAUSE) && press_en.step && !press_en.run;
        do_adv        = bus.ena && (presc_hit || step_ok);
        // The advance always uses the direction held before any coincident dir press.
        nxt           = next_index(index_q, dir_q, LAST_IDX);
    end

    // Prescaler: counts in RUN, parks at zero in PAUSE so a resume gives a full period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
        end else if (bus.ena) begin
            if ((state_q == ST_RUN) && !presc_hit && !press_en.run) begin
                presc_q <= presc_q + PRESC_W'(1);
            end else begin
                presc_q <= '0;
            end
        end
    end

    // RUN/PAUSE toggling and direction toggling from the gated presses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            dir_q   <= DIR_FWD;
        end else begin
            if (press_en.run) begin
                state_q <= (state_q == ST_RUN) ? ST_PAUSE : ST_RUN;
            end
            if (press_en.dir) begin
                dir_q <= ~dir_q;
            end
        end
    end

    // Index update with one-cycle tick/wrap pulses; both stay low whenever ena is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            index_q <= '0;
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            tick_q <= do_adv;
            wrap_q <= do_adv & nxt.wrap;
            if (do_adv) begin
                index_q <= nxt.idx;
            end
        end
    end

    assign bus.index   = index_q;
    assign bus.tick    = tick_q;
    assign bus.wrap    = wrap_q;
    assign bus.running = (state_q == ST_RUN);
    assign bus.dir     = dir_q;

endmodule
